// File: rtl/adder_arbiter.sv
//==============================================================================
// Module   : adder_arbiter
// Brief    : Two-requester adder with a single operation in flight.
//            Round-robin arbitration is enabled by ADDER_ARB_RR_EN.
//            Without it, requester B has fixed priority.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module adder_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_op1,
    input  logic [WIDTH-1:0] a_op2,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_op1,
    input  logic [WIDTH-1:0] b_op2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_carry,
    output logic             resp_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic             r_id;
    logic             w_idle;
    logic             w_prio_a;
    logic             w_grant_a;
    logic             w_grant_b;
    logic [WIDTH:0]   w_sum_full;

`ifdef ADDER_ARB_RR_EN
    // High when A wins the next tie; flips toward the requester not just served
    logic r_ptr_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_a <= 1'b1;
        end else if (a_ready || b_ready) begin
            r_ptr_a <= b_ready;
        end
    end

    assign w_prio_a = r_ptr_a;
`else
    assign w_prio_a = 1'b0;
`endif

    assign w_idle     = (r_state == S_IDLE) && !rst;
    assign w_grant_a  = a_valid && (!b_valid || w_prio_a);
    assign w_grant_b  = b_valid && (!a_valid || !w_prio_a);
    assign a_ready    = w_idle && w_grant_a;
    assign b_ready    = w_idle && w_grant_b;
    assign w_sum_full = {1'b0, r_op1} + {1'b0, r_op2};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op1      <= '0;
            r_op2      <= '0;
            r_id       <= 1'b0;
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_carry <= 1'b0;
            resp_id    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (a_ready) begin
                        r_op1   <= a_op1;
                        r_op2   <= a_op2;
                        r_id    <= 1'b0;
                        r_state <= S_EXEC;
                    end else if (b_ready) begin
                        r_op1   <= b_op1;
                        r_op2   <= b_op2;
                        r_id    <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    {resp_carry, resp_sum} <= w_sum_full;
                    resp_id                <= r_id;
                    resp_valid             <= 1'b1;
                    r_state                <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
//==============================================================================
// Module   : tb_adder_arbiter
// Brief    : Directed self-checking bench for adder_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adder_arbiter;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, b_valid, resp_ready;
    logic             a_ready, b_ready, resp_valid, resp_carry, resp_id;
    logic [WIDTH-1:0] a_op1, a_op2, b_op1, b_op2, resp_sum;

    int checks = 0;
    int passes = 0;

    adder_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_op1      (a_op1),
        .a_op2      (a_op2),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_op1      (b_op1),
        .b_op2      (b_op2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_carry (resp_carry),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs and outputs settle 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; resp_ready = 1'b0;
        a_op1 = '0; a_op2 = '0; b_op1 = '0; b_op2 = '0;
        tick();
        tick();
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", resp_valid); else passes++;
        checks++; if ({resp_carry, resp_sum, resp_id} !== 18'h0) $display("FAIL reset_data got=%h exp=0", {resp_carry, resp_sum, resp_id}); else passes++;
        checks++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {a_ready, b_ready}); else passes++;
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_a_only();
        a_valid = 1'b1; a_op1 = 16'h0010; a_op2 = 16'h0001; resp_ready = 1'b1;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL a_only_grant got=%b exp=10", {a_ready, b_ready}); else passes++;
        tick();                       // handshake edge N
        a_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) $display("FAIL a_only_exec_valid got=%b exp=0", resp_valid); else passes++;
        tick();                       // edge N+1
        checks++; if (resp_valid !== 1'b1) $display("FAIL a_only_valid got=%b exp=1", resp_valid); else passes++;
        checks++; if ({resp_carry, resp_sum, resp_id} !== {1'b0, 16'h0011, 1'b0}) $display("FAIL a_only_data got=%h exp=%h", {resp_carry, resp_sum, resp_id}, {1'b0, 16'h0011, 1'b0}); else passes++;
        tick();                       // edge N+2: response consumed
        checks++; if (resp_valid !== 1'b0) $display("FAIL a_only_drain got=%b exp=0", resp_valid); else passes++;
    endtask

    task automatic test_b_wrap();
        b_valid = 1'b1; b_op1 = 16'hFFFF; b_op2 = 16'h0001; resp_ready = 1'b1;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b01) $display("FAIL b_wrap_grant got=%b exp=01", {a_ready, b_ready}); else passes++;
        tick();
        b_valid = 1'b0;
        tick();
        checks++; if ({resp_valid, resp_carry, resp_sum, resp_id} !== {1'b1, 1'b1, 16'h0000, 1'b1}) $display("FAIL b_wrap_data got=%h exp=%h", {resp_valid, resp_carry, resp_sum, resp_id}, {1'b1, 1'b1, 16'h0000, 1'b1}); else passes++;
        tick();
    endtask

    task automatic test_stall();
        logic ok;
        ok = 1'b1;
        a_valid = 1'b1; a_op1 = 16'h1234; a_op2 = 16'h0100; resp_ready = 1'b0;
        tick();                       // handshake
        a_op1 = 16'hAAAA; a_op2 = 16'h5555; b_op1 = 16'h7777; b_valid = 1'b1;
        tick();                       // now in DONE
        for (int i = 0; i < 5; i++) begin
            a_op1 = a_op1 + 16'h0101;
            #1;
            if (resp_valid !== 1'b1 || resp_sum !== 16'h1334 || resp_carry !== 1'b0 ||
                resp_id !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
                ok = 1'b0;
                $display("FAIL stall_hold cycle=%0d got v=%b sum=%h c=%b id=%b rdy=%b%b exp v=1 sum=1334 c=0 id=0 rdy=00",
                         i, resp_valid, resp_sum, resp_carry, resp_id, a_ready, b_ready);
            end
            tick();
        end
        checks++; if (ok !== 1'b1) $display("FAIL stall_summary got=%b exp=1", ok); else passes++;
        a_valid = 1'b0; b_valid = 1'b0; resp_ready = 1'b1;
        tick();
        checks++; if (resp_valid !== 1'b0) $display("FAIL stall_release got=%b exp=0", resp_valid); else passes++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        a_valid = 1'b1; a_op1 = 16'h1234; a_op2 = 16'h0001; resp_ready = 1'b1;
        tick();                       // handshake, now EXEC
        a_valid = 1'b0; rst = 1'b1;
        tick();
        checks++; if ({resp_valid, resp_sum} !== 17'h0) $display("FAIL rst_mid_out got=%h exp=0", {resp_valid, resp_sum}); else passes++;
        a_valid = 1'b1;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL rst_mid_ready got=%b exp=00", {a_ready, b_ready}); else passes++;
        a_valid = 1'b0; rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid === 1'b1 || resp_sum === 16'h1235) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) $display("FAIL rst_mid_ghost got=%b exp=0", seen); else passes++;
    endtask

    task automatic test_pulse_exec();
        logic seen;
        seen = 1'b0;
        b_valid = 1'b1; b_op1 = 16'h0005; b_op2 = 16'h0006; resp_ready = 1'b1;
        tick();                       // handshake, now EXEC
        b_valid = 1'b0; a_valid = 1'b1; a_op1 = 16'h0100; a_op2 = 16'h0200;
        #1;
        checks++; if (a_ready !== 1'b0) $display("FAIL pulse_ready got=%b exp=0", a_ready); else passes++;
        tick();                       // now DONE
        a_valid = 1'b0;
        checks++; if ({resp_valid, resp_sum, resp_id} !== {1'b1, 16'h000B, 1'b1}) $display("FAIL pulse_resp got=%h exp=%h", {resp_valid, resp_sum, resp_id}, {1'b1, 16'h000B, 1'b1}); else passes++;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (resp_valid === 1'b1 || a_ready === 1'b1) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) $display("FAIL pulse_no_a got=%b exp=0", seen); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_ids;
        int          got;
        int          last_edge;
        int          edge_no;
`ifdef ADDER_ARB_RR_EN
        exp_ids = 4'b1010;            // bit i = id of response i: 0,1,0,1
`else
        exp_ids = 4'b1111;
`endif
        got = 0; last_edge = 0; edge_no = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_valid = 1'b1; a_op1 = 16'h0001; a_op2 = 16'h0002;
        b_valid = 1'b1; b_op1 = 16'h000A; b_op2 = 16'h0014;
        resp_ready = 1'b1;
        while (got < 4 && edge_no < 30) begin
            tick();
            edge_no++;
            if (resp_valid === 1'b1) begin
                checks++; if (resp_id !== exp_ids[got]) $display("FAIL b2b_id idx=%0d got=%b exp=%b", got, resp_id, exp_ids[got]); else passes++;
                checks++; if (resp_sum !== (exp_ids[got] ? 16'h001E : 16'h0003)) $display("FAIL b2b_sum idx=%0d got=%h exp=%h", got, resp_sum, exp_ids[got] ? 16'h001E : 16'h0003); else passes++;
                if (got > 0) begin
                    checks++; if (edge_no - last_edge !== 3) $display("FAIL b2b_interval idx=%0d got=%0d exp=3", got, edge_no - last_edge); else passes++;
                end
                last_edge = edge_no;
                got++;
            end
        end
        checks++; if (got !== 4) $display("FAIL b2b_count got=%0d exp=4", got); else passes++;
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_b_wrap();
        test_stall();
        test_reset_mid();
        test_pulse_exec();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
